rst_msg_ctrl: RTL and testbench

- Message-level controller that sequences one rotating-substitution cipher core.
- Installs a 12-character key by pulsing the core reset, then checking the core's key-error flag.
- Feeds plaintext characters from a valid/ready stream to the core, one strobe per character, and collects each 16-bit ciphertext pair into a single-entry output register.
- Frames messages with a last flag, reports per-message errors and counts encrypted characters.

---
 rtl/rst_msg_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rst_msg_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_msg_ctrl.sv
// rst_msg_ctrl: message-level sequencer for one rotating-substitution cipher core.
//   Key path  : key_in/key_valid/key_ready install a 12-char key by pulsing
//               core_rst_n, then sampling core_err_invalid_key; the result is
//               reported on the sticky key_ok / key_err flags.
//   Input     : s_char/s_valid/s_last/s_ready plaintext stream, one char per
//               core strobe.
//   Output    : m_ctxt/m_valid/m_last/m_err/m_ready single-entry beat register.
//   Status    : msg_err (char dropped in current message), char_count
//               (saturating beat count for current message).
//   Core side : registered core_rst_n/core_key/core_ptxt_char/core_ptxt_valid,
//               and the core's registered ciphertext and error flags.
module rst_msg_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [95:0]      key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             key_ok,
    output logic             key_err,
    input  logic [7:0]       s_char,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [15:0]      m_ctxt,
    output logic             m_valid,
    output logic             m_last,
    output logic             m_err,
    input  logic             m_ready,
    output logic             msg_err,
    output logic [CNT_W-1:0] char_count,
    output logic             core_rst_n,
    output logic [95:0]      core_key,
    output logic [7:0]       core_ptxt_char,
    output logic             core_ptxt_valid,
    input  logic [15:0]      core_ctxt_str,
    input  logic             core_ctxt_ready,
    input  logic             core_err_invalid_key,
    input  logic             core_err_invalid_ptxt,
    input  logic             core_err_key_not_installed
);

    typedef enum logic [2:0] {
        NO_KEY,
        KEY_RST,
        KEY_CHK,
        KEY_EVAL,
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t state, state_nxt;
    logic   in_msg;
    logic   last_q;
    logic   key_acc;
    logic   char_acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NO_KEY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            NO_KEY:   if (key_acc) state_nxt = KEY_RST;
            KEY_RST:  state_nxt = KEY_CHK;
            KEY_CHK:  state_nxt = KEY_EVAL;
            KEY_EVAL: state_nxt = core_err_invalid_key ? NO_KEY : IDLE;
            IDLE: begin
                if (key_acc) begin
                    state_nxt = KEY_RST;
                end else if (char_acc) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:    state_nxt = CAPTURE;
            CAPTURE:  state_nxt = IDLE;
            default:  state_nxt = NO_KEY;
        endcase
    end

    // Handshake outputs; a key request takes priority over plaintext in IDLE.
    always_comb begin
        key_ready = (state == NO_KEY) || ((state == IDLE) && !in_msg && !m_valid);
        key_acc   = key_valid && key_ready;
        s_ready   = (state == IDLE) && !m_valid && !key_acc;
        char_acc  = s_valid && s_ready;
    end

    // Registered datapath, flags and core drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_ok          <= 1'b0;
            key_err         <= 1'b0;
            m_ctxt          <= '0;
            m_valid         <= 1'b0;
            m_last          <= 1'b0;
            m_err           <= 1'b0;
            msg_err         <= 1'b0;
            char_count      <= '0;
            core_rst_n      <= 1'b0;
            core_key        <= '0;
            core_ptxt_char  <= '0;
            core_ptxt_valid <= 1'b0;
            in_msg          <= 1'b0;
            last_q          <= 1'b0;
        end else begin
            // Core reset is low exactly while the FSM sits in KEY_RST.
            core_rst_n      <= (state_nxt != KEY_RST);
            // One-cycle strobe: the core rotates its table on every strobe.
            core_ptxt_valid <= char_acc;

            if (key_acc) begin
                core_key <= key_in;
                key_ok   <= 1'b0;
                key_err  <= 1'b0;
            end

            if (state == KEY_EVAL) begin
                if (core_err_invalid_key) begin
                    key_err <= 1'b1;
                end else begin
                    key_ok  <= 1'b1;
                end
            end

            if (char_acc) begin
                core_ptxt_char <= s_char;
                last_q         <= s_last;
                if (!in_msg) begin
                    msg_err    <= 1'b0;
                    char_count <= '0;
                    in_msg     <= 1'b1;
                end
            end

            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            // m_valid is always clear here: a char is only accepted with an empty output register.
            if (state == CAPTURE) begin
                if (core_ctxt_ready) begin
                    m_ctxt  <= core_ctxt_str;
                    m_valid <= 1'b1;
                    m_last  <= last_q;
                    m_err   <= 1'b0;
                    if (char_count != '1) begin
                        char_count <= char_count + 1'b1;
                    end
                end else begin
                    msg_err <= 1'b1;
                    if (last_q) begin
                        m_ctxt  <= '0;
                        m_valid <= 1'b1;
                        m_last  <= 1'b1;
                        m_err   <= 1'b1;
                    end
                end
                if (last_q) begin
                    in_msg <= 1'b0;
                end
            end
        end
    end

    // Not-installed is handled identically to an invalid character.
    logic unused_core_flags;
    assign unused_core_flags = core_err_invalid_ptxt ^ core_err_key_not_installed;

endmodule

// File: tb/tb_rst_msg_ctrl.sv
// tb_rst_msg_ctrl: self-checking bench for rst_msg_ctrl with a behavioural
// cipher-core model and a queue-based message scoreboard.
module tb_rst_msg_ctrl;

    localparam int CNT_W = 3;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [95:0]      key_in = '0;
    logic             key_valid = 1'b0;
    logic             key_ready, key_ok, key_err;
    logic [7:0]       s_char = '0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic [15:0]      m_ctxt;
    logic             m_valid, m_last, m_err;
    logic             m_ready = 1'b0;
    logic             msg_err;
    logic [CNT_W-1:0] char_count;
    logic             core_rst_n;
    logic [95:0]      core_key;
    logic [7:0]       core_ptxt_char;
    logic             core_ptxt_valid;
    logic [15:0]      core_ctxt_str = '0;
    logic             core_ctxt_ready = 1'b0;
    logic             core_err_invalid_key = 1'b0;
    logic             core_err_invalid_ptxt = 1'b0;
    logic             core_err_key_not_installed = 1'b0;

    rst_msg_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .key_ok(key_ok), .key_err(key_err),
        .s_char(s_char), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_ctxt(m_ctxt), .m_valid(m_valid), .m_last(m_last), .m_err(m_err),
        .m_ready(m_ready), .msg_err(msg_err), .char_count(char_count),
        .core_rst_n(core_rst_n), .core_key(core_key),
        .core_ptxt_char(core_ptxt_char), .core_ptxt_valid(core_ptxt_valid),
        .core_ctxt_str(core_ctxt_str), .core_ctxt_ready(core_ctxt_ready),
        .core_err_invalid_key(core_err_invalid_key),
        .core_err_invalid_ptxt(core_err_invalid_ptxt),
        .core_err_key_not_installed(core_err_key_not_installed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- cipher rules shared by core model and scoreboard -----
    function automatic logic [7:0] kbyte(input logic [95:0] k, input int unsigned i);
        return k[95 - 8*i -: 8];
    endfunction

    function automatic bit is_letter(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a);
    endfunction

    function automatic bit key_is_valid(input logic [95:0] k);
        for (int i = 0; i < 12; i++) begin
            if (kbyte(k, i) < 8'h61 || kbyte(k, i) > 8'h7a) return 1'b0;
            for (int j = 0; j < i; j++)
                if (kbyte(k, i) == kbyte(k, j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Letter index plus three cells per rotation, over six key pairs.
    function automatic logic [15:0] cipher(input logic [95:0] k, input int unsigned rot,
                                           input logic [7:0] ch);
        logic [7:0] c;
        int unsigned p;
        c = (ch >= 8'h41 && ch <= 8'h5a) ? ch + 8'd32 : ch;
        p = (32'(c - 8'h61) + 3 * rot) % 6;
        return {kbyte(k, 2*p), kbyte(k, 2*p + 1)};
    endfunction

    // ---------------- cipher core model (registered outputs) ---------------
    logic        c_installed = 1'b0;
    int unsigned c_rot = 0;

    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            c_installed                <= key_is_valid(core_key);
            core_err_invalid_key       <= !key_is_valid(core_key);
            core_ctxt_ready            <= 1'b0;
            core_err_invalid_ptxt      <= 1'b0;
            core_err_key_not_installed <= 1'b0;
            core_ctxt_str              <= '0;
            c_rot                      <= 0;
        end else begin
            core_ctxt_ready            <= 1'b0;
            core_err_invalid_ptxt      <= 1'b0;
            core_err_key_not_installed <= 1'b0;
            if (core_ptxt_valid) begin
                c_rot <= c_rot + 1;
                if (!c_installed) begin
                    core_err_key_not_installed <= 1'b1;
                end else if (!is_letter(core_ptxt_char)) begin
                    core_err_invalid_ptxt <= 1'b1;
                end else begin
                    core_ctxt_ready <= 1'b1;
                    core_ctxt_str   <= cipher(core_key, c_rot, core_ptxt_char);
                end
            end
        end
    end

    // ---------------- message-level scoreboard ------------------------------
    typedef struct {
        logic [15:0] ctxt;
        logic        last;
        logic        err;
        int unsigned cnt;
        logic        merr;
    } beat_t;

    beat_t       exp_q[$];
    logic [95:0] m_key = '0;
    int unsigned m_rot = 0;
    bit          m_in_msg = 1'b0;
    int unsigned m_cnt = 0;
    bit          m_merr = 1'b0;

    function automatic void model_accept(input logic [7:0] ch, input logic last);
        beat_t b;
        if (!m_in_msg) begin
            m_cnt = 0;
            m_merr = 1'b0;
            m_in_msg = 1'b1;
        end
        if (is_letter(ch)) begin
            m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
            b = '{ctxt: cipher(m_key, m_rot, ch), last: last, err: 1'b0, cnt: m_cnt, merr: m_merr};
            exp_q.push_back(b);
        end else begin
            m_merr = 1'b1;
            if (last) begin
                b = '{ctxt: 16'h0000, last: 1'b1, err: 1'b1, cnt: m_cnt, merr: 1'b1};
                exp_q.push_back(b);
            end
        end
        m_rot++;
        if (last) m_in_msg = 1'b0;
    endfunction

    // ---------------- downstream ready and monitors --------------------------
    bit hold = 1'b0;
    bit bp   = 1'b0;

    always @(negedge clk) begin
        if (hold) m_ready = 1'b0;
        else if (bp) m_ready = ($urandom_range(0, 3) != 0);
        else m_ready = 1'b1;
    end

    always @(negedge clk) begin
        beat_t b;
        #2;
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(m_ctxt), 32'hffff_ffff);
            end else begin
                b = exp_q.pop_front();
                check("m_ctxt", 32'(m_ctxt), 32'(b.ctxt));
                check("m_last", 32'(m_last), 32'(b.last));
                check("m_err", 32'(m_err), 32'(b.err));
                check("char_count", 32'(char_count), b.cnt);
                check("msg_err", 32'(msg_err), 32'(b.merr));
            end
        end
    end

    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (core_ptxt_valid) check("strobe_width", 32'(prev_strobe), 32'd0);
        prev_strobe = core_ptxt_valid;
    end

    // ---------------- stimulus tasks ----------------------------------------
    task automatic install(input logic [95:0] k);
        int unsigned n = 0;
        bit exp_ok;
        exp_ok = key_is_valid(k);
        @(negedge clk);
        key_in = k;
        key_valid = 1'b1;
        #1;
        while (!key_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check("key_ready_wait", 32'(key_ready), 32'd1);
        @(posedge clk);
        #1 key_valid = 1'b0;
        m_key = k;
        m_rot = 0;
        @(negedge clk); #1;
        check("core_rst_low", 32'(core_rst_n), 32'd0);
        check("key_ok_clear", 32'(key_ok), 32'd0);
        check("core_key", 32'(core_key == k), 32'd1);
        @(negedge clk); #1;
        check("core_rst_high", 32'(core_rst_n), 32'd1);
        @(negedge clk); #1;
        check("key_ok_early", 32'(key_ok), 32'd0);
        @(negedge clk); #1;
        check("key_ok", 32'(key_ok), 32'(exp_ok));
        check("key_err", 32'(key_err), 32'(!exp_ok));
    endtask

    task automatic send_char(input logic [7:0] ch, input logic last);
        int unsigned n = 0;
        @(negedge clk);
        s_char = ch;
        s_valid = 1'b1;
        s_last = last;
        #1;
        while (!s_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            return;
        end
        model_accept(ch, last);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 500) begin
            @(negedge clk); n++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    function automatic logic [95:0] rand_key();
        logic [7:0] pool[26];
        logic [7:0] t;
        logic [95:0] k;
        int unsigned j;
        for (int i = 0; i < 26; i++) pool[i] = 8'h61 + 8'(i);
        for (int i = 25; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = pool[i]; pool[i] = pool[j]; pool[j] = t;
        end
        for (int i = 0; i < 12; i++) k[95 - 8*i -: 8] = pool[i];
        return k;
    endfunction

    function automatic logic [7:0] rand_char();
        int unsigned r;
        logic [7:0] odd[4];
        odd = '{8'h21, 8'h30, 8'h40, 8'h20};
        r = $urandom_range(0, 99);
        if (r < 70) return 8'h61 + 8'($urandom_range(0, 25));
        if (r < 85) return 8'h41 + 8'($urandom_range(0, 25));
        return odd[$urandom_range(0, 3)];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    localparam logic [95:0] KEY_GOOD = "abcdefghijkl";
    localparam logic [95:0] KEY_BAD  = "aacdefghijkl";

    initial begin
        logic [15:0] held;
        int unsigned n;
        int unsigned len;

        // Reset values
        #12;
        check("rst_key_ok", 32'(key_ok), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_core_key", 32'(core_key[95:64] | core_key[63:32] | core_key[31:0]), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk); #1;
        check("core_rst_release", 32'(core_rst_n), 32'd1);
        check("nokey_key_ready", 32'(key_ready), 32'd1);

        // Good key, then message "aa"
        install(KEY_GOOD);
        send_char(8'h61, 1'b0);
        send_char(8'h61, 1'b1);
        drain();

        // Bad key: NO_KEY refuses characters
        install(KEY_BAD);
        @(negedge clk);
        s_valid = 1'b1; s_char = 8'h61; s_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("nokey_s_ready", 32'(s_ready), 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;

        // Fresh key, uppercase single-character message
        install(KEY_GOOD);
        send_char(8'h41, 1'b1);
        drain();

        // Valid char then invalid last char -> terminator
        send_char(8'h61, 1'b0);
        send_char(8'h21, 1'b1);
        drain();

        // Key request wins over a simultaneous character
        @(negedge clk);
        s_valid = 1'b1; s_char = 8'h7a; s_last = 1'b1;
        key_valid = 1'b1; key_in = KEY_GOOD;
        #1;
        check("collide_s_ready", 32'(s_ready), 32'd0);
        check("collide_key_ready", 32'(key_ready), 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0; key_valid = 1'b0;
        m_key = KEY_GOOD; m_rot = 0;
        repeat (4) @(negedge clk);
        #1 check("collide_key_ok", 32'(key_ok), 32'd1);

        // Backpressure hold, then asynchronous reset mid-message
        hold = 1'b1;
        send_char(8'h62, 1'b0);
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("hold_m_valid", 32'(m_valid), 32'd1);
        held = m_ctxt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("hold_ctxt", 32'(m_ctxt), 32'(held));
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check("hold_strobe", 32'(core_ptxt_valid), 32'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_key_ok", 32'(key_ok), 32'd0);
        check("arst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("arst_char_count", 32'(char_count), 32'd0);
        check("arst_msg_err", 32'(msg_err), 32'd0);
        check("arst_core_key", 32'(core_key[95:64] | core_key[63:32] | core_key[31:0]), 32'd0);
        exp_q.delete();
        m_in_msg = 1'b0;
        hold = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_key_ready", 32'(key_ready), 32'd1);
        check("post_rst_s_ready", 32'(s_ready), 32'd0);

        // Randomized messages under random backpressure
        install(KEY_GOOD);
        bp = 1'b1;
        for (int m = 0; m < 30; m++) begin
            if ($urandom_range(0, 5) == 0) install(rand_key());
            len = $urandom_range(1, 10);
            for (int c = 0; c < int'(len); c++) send_char(rand_char(), c == int'(len) - 1);
            drain();
        end
        bp = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
